// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - boot loader that streams a length-prefixed image into instruction memory
// Holds the CPU in reset until the image is written, then serves fetches from the memory.
module imem_boot_ctrl #(
    parameter int DEPTH = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [7:0]                     in_data,
    output logic                           in_ready,
    input  logic                           reload,
    output logic                           mem_we,
    output logic [$clog2(DEPTH)-1:0]       mem_waddr,
    output logic [7:0]                     mem_wdata,
    output logic [$clog2(DEPTH)-1:0]       mem_raddr,
    input  logic [31:0]                    mem_rdata,
    input  logic [31:0]                    cpu_addr,
    output logic [31:0]                    cpu_instr,
    output logic                           cpu_rst,
    output logic                           done,
    output logic                           err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {HDR0, HDR1, LOAD, RUN, ERR} state_t;

    state_t      state;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [15:0] hdr_len;
    logic        accept;
    logic        unused_addr_bits;

    assign in_ready  = (state == HDR0) || (state == HDR1) || (state == LOAD);
    assign accept    = in_valid && in_ready;
    assign hdr_len   = {in_data, len[7:0]};
    assign done      = (state == RUN);
    assign err       = (state == ERR);
    assign mem_raddr = (state == RUN) ? cpu_addr[AW-1:0] : {AW{1'b0}};
    assign cpu_instr = (state == RUN) ? mem_rdata : 32'h0000_0000;
    assign unused_addr_bits = ^cpu_addr[31:AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR0;
            len       <= 16'd0;
            cnt       <= 16'd0;
            mem_we    <= 1'b0;
            mem_waddr <= {AW{1'b0}};
            mem_wdata <= 8'h00;
            cpu_rst   <= 1'b1;
        end else begin
            mem_we  <= 1'b0;
            // Registered from the current state so the final byte write lands before release.
            cpu_rst <= (state != RUN);
            case (state)
                HDR0: begin
                    if (accept) begin
                        len   <= {8'h00, in_data};
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        len <= hdr_len;
                        cnt <= 16'd0;
                        if ({16'd0, hdr_len} > 32'(DEPTH))
                            state <= ERR;
                        else if (hdr_len == 16'd0)
                            state <= RUN;
                        else
                            state <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= cnt[AW-1:0];
                        mem_wdata <= in_data;
                        cnt       <= cnt + 16'd1;
                        if (cnt == len - 16'd1)
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (reload) begin
                        state <= HDR0;
                        len   <= 16'd0;
                        cnt   <= 16'd0;
                    end
                end
                ERR: state <= ERR;
                default: state <= HDR0;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - directed vector bench for imem_boot_ctrl
module tb_imem_boot_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_raddr;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_instr;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    imem_boot_ctrl #(.DEPTH(256)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .cpu_addr(cpu_addr),
        .cpu_instr(cpu_instr), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  data;
        logic        rld;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        rdy;
        logic        we;
        logic [7:0]  wa;
        logic [7:0]  wd;
        logic        crst;
        logic        dn;
        logic        er;
        logic [31:0] instr;
        logic [7:0]  raddr;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rl);
        rst = r; in_valid = v; in_data = d; reload = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_hdr0(input string tag);
        chk({tag, "_rdy"},  32'(in_ready), 32'd1);
        chk({tag, "_we"},   32'(mem_we),   32'd0);
        chk({tag, "_wa"},   32'(mem_waddr), 32'd0);
        chk({tag, "_wd"},   32'(mem_wdata), 32'd0);
        chk({tag, "_crst"}, 32'(cpu_rst),  32'd1);
        chk({tag, "_done"}, 32'(done),     32'd0);
    endtask

    localparam logic [31:0] A = 32'h0000_0104;
    localparam logic [31:0] R = 32'h2010_0AF0;
    localparam logic [31:0] B = 32'hDEAD_BEEF;

    initial begin
        //            rst vld data  rld addr rdata | rdy we wa     wd     crst dn er instr raddr
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, A, R, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h04, 1'b0, A, R, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, A, R, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 8'h13, 1'b0, A, R, 1'b1, 1'b1, 8'h00, 8'h13, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 8'h77, 1'b0, A, R, 1'b1, 1'b0, 8'h00, 8'h13, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, A, R, 1'b1, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, A, R, 1'b1, 1'b1, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 8'h20, 1'b0, A, R, 1'b0, 1'b1, 8'h03, 8'h20, 1'b1, 1'b1, 1'b0, R,     8'h04};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, A, R, 1'b0, 1'b0, 8'h03, 8'h20, 1'b0, 1'b1, 1'b0, R,     8'h04};
        tbl[9]  = '{1'b0, 1'b1, 8'h55, 1'b0, A, R, 1'b0, 1'b0, 8'h03, 8'h20, 1'b0, 1'b1, 1'b0, R,     8'h04};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, A, R, 1'b1, 1'b0, 8'h03, 8'h20, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, A, R, 1'b1, 1'b0, 8'h03, 8'h20, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b0, A, R, 1'b1, 1'b0, 8'h03, 8'h20, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[13] = '{1'b0, 1'b1, 8'h00, 1'b0, 32'hFC, B, 1'b0, 1'b0, 8'h03, 8'h20, 1'b1, 1'b1, 1'b0, B, 8'hFC};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'hFC, B, 1'b0, 1'b0, 8'h03, 8'h20, 1'b0, 1'b1, 1'b0, B, 8'hFC};
        tbl[15] = '{1'b0, 1'b1, 8'h01, 1'b1, A, R, 1'b1, 1'b0, 8'h03, 8'h20, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[16] = '{1'b0, 1'b1, 8'h01, 1'b0, A, R, 1'b1, 1'b0, 8'h03, 8'h20, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00};
        tbl[17] = '{1'b0, 1'b1, 8'h01, 1'b0, A, R, 1'b0, 1'b0, 8'h03, 8'h20, 1'b1, 1'b0, 1'b1, 32'h0, 8'h00};
        tbl[18] = '{1'b0, 1'b1, 8'h02, 1'b1, A, R, 1'b0, 1'b0, 8'h03, 8'h20, 1'b1, 1'b0, 1'b1, 32'h0, 8'h00};

        foreach (tbl[i]) begin
            cpu_addr  = tbl[i].addr;
            mem_rdata = tbl[i].rdata;
            step(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].rld);
            chk($sformatf("row%0d_rdy", i),   32'(in_ready),  32'(tbl[i].rdy));
            chk($sformatf("row%0d_we", i),    32'(mem_we),    32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("row%0d_wa", i), 32'(mem_waddr), 32'(tbl[i].wa));
                chk($sformatf("row%0d_wd", i), 32'(mem_wdata), 32'(tbl[i].wd));
            end
            chk($sformatf("row%0d_crst", i),  32'(cpu_rst),   32'(tbl[i].crst));
            chk($sformatf("row%0d_done", i),  32'(done),      32'(tbl[i].dn));
            chk($sformatf("row%0d_err", i),   32'(err),       32'(tbl[i].er));
            chk($sformatf("row%0d_instr", i), cpu_instr,      tbl[i].instr);
            chk($sformatf("row%0d_raddr", i), 32'(mem_raddr), 32'(tbl[i].raddr));
        end

        // ERR must hold for 100 cycles whatever the stream and reload do
        begin
            int bad = 0;
            for (int c = 0; c < 100; c++) begin
                step(1'b0, 1'b1, 8'(c), c[0]);
                if (!err || in_ready || !cpu_rst || done || mem_we || cpu_instr != 32'h0) bad++;
            end
            chk("err_hold_bad_cycles", 32'(bad), 32'd0);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk_idle_hdr0("err_rst");
        chk("err_rst_err", 32'(err), 32'd0);

        // len == DEPTH with in_valid toggling: 256 in-order writes, no wrap
        begin
            int sent = 0;
            int writes = 0;
            int cyc = 0;
            logic acc;
            step(1'b0, 1'b1, 8'h00, 1'b0);
            step(1'b0, 1'b1, 8'h01, 1'b0);
            while ((sent < 256 || cyc < 4) && cyc < 2000) begin
                if (sent >= 256) cyc += 1000;
                in_valid = (cyc % 2 == 0) && (sent < 256);
                in_data  = 8'(sent) ^ 8'h5A;
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (acc) sent++;
                if (mem_we) begin
                    chk($sformatf("full_wa%0d", writes), 32'(mem_waddr), 32'(writes % 256));
                    chk($sformatf("full_wd%0d", writes), 32'(mem_wdata), 32'(8'(writes) ^ 8'h5A));
                    writes++;
                end
                cyc++;
            end
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b0, 8'h00, 1'b0);
                if (mem_we) writes++;
            end
            chk("full_sent", 32'(sent), 32'd256);
            chk("full_writes", 32'(writes), 32'd256);
            chk("full_done", 32'(done), 32'd1);
            chk("full_crst", 32'(cpu_rst), 32'd0);
        end

        // reset mid-LOAD with a concurrent byte, then a fresh 2-byte image
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h04, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("abort_w0_wa", 32'(mem_waddr), 32'h00);
        step(1'b0, 1'b1, 8'hBB, 1'b0);
        chk("abort_w1_wa", 32'(mem_waddr), 32'h01);
        step(1'b1, 1'b1, 8'hCC, 1'b0);
        chk_idle_hdr0("abort_rst");
        step(1'b0, 1'b1, 8'h02, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        chk("new_w0_we", 32'(mem_we), 32'd1);
        chk("new_w0_wa", 32'(mem_waddr), 32'h00);
        chk("new_w0_wd", 32'(mem_wdata), 32'h11);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        chk("new_w1_wa", 32'(mem_waddr), 32'h01);
        chk("new_w1_wd", 32'(mem_wdata), 32'h22);
        chk("new_done", 32'(done), 32'd1);
        chk("new_crst_first_run", 32'(cpu_rst), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("new_crst_release", 32'(cpu_rst), 32'd0);
        chk("new_no_extra_we", 32'(mem_we), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("reload_rdy", 32'(in_ready), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("reload_crst", 32'(cpu_rst), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the instruction memory size in bytes (power of two).
REQ-002 SHALL have derived localparam AW = $clog2(DEPTH), the byte-address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  boot byte stream valid.
REQ-006 SHALL have port in_data  input  8  boot byte.
REQ-007 SHALL have port in_ready  output  1  controller accepts a byte this cycle.
REQ-008 SHALL have port reload  input  1  single-cycle request to restart loading from RUN.
REQ-009 SHALL have port mem_we  output  1  byte write strobe to the instruction memory.
REQ-010 SHALL have port mem_waddr  output  AW  byte write address.
REQ-011 SHALL have port mem_wdata  output  8  byte write data.
REQ-012 SHALL have port mem_raddr  output  AW  read address to the instruction memory.
REQ-013 SHALL have port mem_rdata  input  32  little-endian word returned by the memory for mem_raddr.
REQ-014 SHALL have port cpu_addr  input  32  CPU fetch address (PC).
REQ-015 SHALL have port cpu_instr  output  32  instruction delivered to the CPU.
REQ-016 SHALL have port cpu_rst  output  1  active-high hold of the CPU core.
REQ-017 SHALL have port done  output  1  image loaded, CPU running.
REQ-018 SHALL have port err  output  1  image length rejected.

Function
REQ-019 SHALL implement states HDR0, HDR1, LOAD, RUN, ERR; a byte is accepted when in_valid && in_ready.
REQ-020 SHALL drive in_ready = 1 in HDR0, HDR1, LOAD; 0 in RUN and ERR (combinational from state).
REQ-021 HDR0: on accept, SHALL store byte as len[7:0] and go to HDR1.
REQ-022 HDR1: on accept, SHALL form len = {byte, len[7:0]} (16 bits); len > DEPTH -> ERR; len == 0 -> RUN; else -> LOAD with byte counter cnt = 0.
REQ-023 LOAD: on accept, SHALL register mem_we=1, mem_waddr=cnt[AW-1:0], mem_wdata=byte for exactly the next cycle (1-cycle latency), then cnt += 1.
REQ-024 LOAD: the accept with cnt == len-1 SHALL transition to RUN; no further bytes accepted.
REQ-025 SHALL drive mem_we = 0 in every cycle not immediately following a LOAD accept; no write ever issued from HDR0/HDR1/RUN/ERR accepts.
REQ-026 Idle cycles (in_valid=0) in any loading state SHALL hold state, cnt and len unchanged.
REQ-027 SHALL register cpu_rst = (state != RUN) each cycle, so cpu_rst stays 1 in the first RUN cycle and the last byte write completes before CPU release.
REQ-028 SHALL drive mem_raddr = cpu_addr[AW-1:0] in RUN, else {AW{1'b0}}.
REQ-029 SHALL drive cpu_instr = mem_rdata in RUN, else 32'h0000_0000 (NOP).
REQ-030 SHALL drive done = (state == RUN) and err = (state == ERR), combinational.
REQ-031 RUN: reload=1 SHALL go to HDR0 next cycle, clearing len and cnt; cpu_rst re-asserts the following cycle; reload ignored in all other states.
REQ-032 ERR SHALL be terminal until rst; in_ready=0 and cpu_rst=1 throughout.
REQ-033 len == DEPTH SHALL be accepted and fill addresses 0..DEPTH-1 with no address wrap.

Reset
REQ-034 rst=1 SHALL, at the next edge, force state=HDR0, len=0, cnt=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_rst=1, overriding any concurrent accept or reload.
REQ-035 rst asserted mid-LOAD SHALL abort the load; the partially written image is not erased; loading restarts at HDR0.

Verification
REQ-036 Stream 04 00 13 00 00 20, in_valid continuous -> writes (0,13),(1,00),(2,00),(3,20) on four consecutive cycles; done=1 after the 6th accept; cpu_rst falls one cycle later.
REQ-037 Header 00 00 -> RUN straight after HDR1, no mem_we pulse, cpu_rst falls 2 cycles after the 2nd accept.
REQ-038 Header 01 01 (len 257, DEPTH 256) -> err=1, in_ready=0, cpu_rst=1 held for 100 cycles; rst returns to HDR0.
REQ-039 len 256 with in_valid toggling every other cycle -> exactly 256 writes, addresses 0..255 in order, none duplicated.
REQ-040 In RUN, cpu_addr=0x0000_0104 with mem_rdata=0x2010_0AF0 -> mem_raddr=0x04, cpu_instr=0x2010_0AF0; before RUN cpu_instr=0.
REQ-041 rst after 2 of 4 LOAD bytes, then a new 2-byte image -> new writes start at address 0; reload in RUN restarts load with cpu_rst re-asserted.
